// File: rtl/pdua_int_pkg.sv
// ============================================================================
// Module   : pdua_int_pkg
// Brief    : Shared types, defaults and priority encoder for pdua_int_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pdua_int_pkg;

    localparam int DEF_NUM_SRC   = 8;
    localparam int DEF_VEC_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    // Scans downward so the last hit, i.e. the lowest set index, wins.
    function automatic logic [4:0] prio_lowest(input logic [31:0] req);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdua_edge_det.sv
// ============================================================================
// Module   : pdua_edge_det
// Brief    : Parameterised-width rising-edge detector (delay register + AND).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pdua_edge_det #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sig_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d_q <= '0;
        end else begin
            sig_d_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_d_q;

endmodule

`default_nettype wire

// File: rtl/pdua_int_ctrl.sv
// ============================================================================
// Module   : pdua_int_ctrl
// Brief    : PDUA interrupt requester: edge-latched pending bits, enable mask,
//            lowest-index priority, INT pulse / int_clr handshake with retry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pdua_int_ctrl
    import pdua_int_pkg::*;
#(
    parameter int                  NUM_SRC      = DEF_NUM_SRC,
    parameter int                  VEC_WIDTH    = DEF_VEC_WIDTH,
    parameter int                  RETRY_CYCLES = 255,
    parameter logic [NUM_SRC-1:0]  MASK_RESET   = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   irq,
    input  logic                 mask_we,
    input  logic [NUM_SRC-1:0]   mask_wdata,
    input  logic                 int_clr,
    output logic                 INT,
    output logic [VEC_WIDTH-1:0] int_vec,
    output logic [NUM_SRC-1:0]   pending,
    output logic [NUM_SRC-1:0]   mask,
    output logic                 busy
);

    localparam int CNT_W = ($clog2(RETRY_CYCLES + 1) > 8) ? $clog2(RETRY_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);

    state_t               state_q, state_d;
    logic [VEC_WIDTH-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   eligible;
    logic [VEC_WIDTH-1:0] winner;
    logic                 ack;

    pdua_edge_det #(
        .WIDTH (NUM_SRC)
    ) u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (irq),
        .rise_o (rise)
    );

    assign eligible = pending_q & mask_q;
    assign winner   = VEC_WIDTH'(prio_lowest(32'(eligible)));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    vec_d   = winner;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                cnt_d = '0;
                if (int_clr) begin
                    ack     = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (int_clr) begin
                    ack     = 1'b1;
                    state_d = ST_GAP;
                end else if ((RETRY_CYCLES != 0) && (cnt_q == RETRY_LAST)) begin
                    state_d = ST_PULSE;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear before OR-ing new rises so a same-cycle re-request stays pending.
        pending_d = pending_q;
        if (ack) begin
            pending_d[vec_q] = 1'b0;
        end
        pending_d = pending_d | rise;

        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RESET;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign INT     = (state_q == ST_PULSE);
    assign busy    = (state_q != ST_IDLE);
    assign int_vec = vec_q;
    assign pending = pending_q;
    assign mask    = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_pdua_int_ctrl.sv
// ============================================================================
// Module   : tb_pdua_int_ctrl
// Brief    : Scoreboard bench for pdua_int_ctrl (RETRY_CYCLES = 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pdua_int_ctrl;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] irq        = 8'h00;
    logic       mask_we    = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic       int_clr    = 1'b0;
    logic       INT;
    logic [2:0] int_vec;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       busy;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] vec;
        int         at;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pdua_int_ctrl #(
        .NUM_SRC      (8),
        .VEC_WIDTH    (3),
        .RETRY_CYCLES (4),
        .MASK_RESET   (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_clr    (int_clr),
        .INT        (INT),
        .int_vec    (int_vec),
        .pending    (pending),
        .mask       (mask),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_int(input logic [2:0] v, input int at);
        sb.push_back('{v, at});
    endtask

    // Every INT pulse must match the oldest expectation in vector and cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && INT) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_int: INT=1 int_vec=%0d at cycle %0d, none expected", int_vec, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("int_vec", 32'(int_vec), 32'(e.vec));
                    chk("int_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    endtask

    task automatic wait_int(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (INT) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic ack();
        tick();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_int",     32'(INT),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_mask",    32'(mask),    32'hFF);
        chk("rst_vec",     32'(int_vec), 32'd0);

        // Single source 5
        irq = 8'h20;
        expect_int(3'd5, cyc + 2);
        tick();
        irq = 8'h00;
        chk("t1_pending_set", 32'(pending), 32'h20);
        chk("t1_busy_idle",   32'(busy),    32'd0);
        wait_int("t1_int_seen");
        chk("t1_busy_pulse",  32'(busy),    32'd1);
        ack();
        chk("t1_pending_clr", 32'(pending), 32'h00);
        chk("t1_busy_gap",    32'(busy),    32'd1);
        tick();
        chk("t1_busy_done",   32'(busy),    32'd0);

        // Simultaneous 6 and 2: lowest index first, then earliest respacing
        irq = 8'h44;
        expect_int(3'd2, cyc + 2);
        tick();
        irq = 8'h00;
        chk("t2_pending", 32'(pending), 32'h44);
        wait_int("t2_int_a");
        ack();
        chk("t2_pending_left", 32'(pending), 32'h40);
        expect_int(3'd6, cyc + 2);
        wait_int("t2_int_b");
        ack();
        tick();
        chk("t2_pending_clr", 32'(pending), 32'h00);
        chk("t2_busy_done",   32'(busy),    32'd0);

        // Masked source latches but waits for its enable
        mask_we    = 1'b1;
        mask_wdata = 8'hFB;
        tick();
        mask_we = 1'b0;
        chk("t3_mask_fb", 32'(mask), 32'hFB);
        irq = 8'h04;
        tick();
        irq = 8'h00;
        chk("t3_pending_masked", 32'(pending), 32'h04);
        repeat (3) tick();
        chk("t3_busy_masked",  32'(busy),    32'd0);
        chk("t3_pending_hold", 32'(pending), 32'h04);
        mask_we    = 1'b1;
        mask_wdata = 8'hFF;
        expect_int(3'd2, cyc + 2);
        tick();
        mask_we = 1'b0;
        chk("t3_mask_ff", 32'(mask), 32'hFF);
        wait_int("t3_int");
        ack();
        tick();
        chk("t3_pending_clr", 32'(pending), 32'h00);

        // Retry every RETRY_CYCLES+1 = 5 cycles, ack on third pulse
        irq = 8'h01;
        expect_int(3'd0, cyc + 2);
        expect_int(3'd0, cyc + 7);
        expect_int(3'd0, cyc + 12);
        tick();
        irq = 8'h00;
        wait_int("t4_pulse1");
        wait_int("t4_pulse2");
        wait_int("t4_pulse3");
        ack();
        repeat (8) tick();
        chk("t4_pending_clr", 32'(pending), 32'h00);
        chk("t4_busy_done",   32'(busy),    32'd0);

        // Re-rise of source 3 in the acknowledge cycle keeps it pending
        irq = 8'h08;
        expect_int(3'd3, cyc + 2);
        tick();
        irq = 8'h00;
        wait_int("t5_int_a");
        tick();
        int_clr = 1'b1;
        irq     = 8'h08;
        tick();
        int_clr = 1'b0;
        irq     = 8'h00;
        chk("t5_pending_kept", 32'(pending), 32'h08);
        chk("t5_busy_gap",     32'(busy),    32'd1);
        expect_int(3'd3, cyc + 2);
        wait_int("t5_int_b");
        ack();
        tick();
        chk("t5_pending_clr", 32'(pending), 32'h00);

        // Async reset mid-service, after a mask write that must not disturb it
        irq = 8'h0A;
        expect_int(3'd1, cyc + 2);
        tick();
        irq = 8'h00;
        wait_int("t6_int");
        tick();
        mask_we    = 1'b1;
        mask_wdata = 8'hF0;
        tick();
        mask_we = 1'b0;
        chk("t6_vec_held",  32'(int_vec), 32'd1);
        chk("t6_mask_f0",   32'(mask),    32'hF0);
        chk("t6_pending",   32'(pending), 32'h0A);
        chk("t6_busy_wait", 32'(busy),    32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_int",     32'(INT),     32'd0);
        chk("t6_rst_pending", 32'(pending), 32'h00);
        chk("t6_rst_busy",    32'(busy),    32'd0);
        chk("t6_rst_vec",     32'(int_vec), 32'd0);
        chk("t6_rst_mask",    32'(mask),    32'hFF);
        tick();
        tick();
        rst     = 1'b0;
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        tick();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        repeat (3) tick();
        chk("t6_idle_busy",    32'(busy),    32'd0);
        chk("t6_idle_pending", 32'(pending), 32'h00);

        // Highest index after reset still serviced
        irq = 8'h80;
        expect_int(3'd7, cyc + 2);
        tick();
        irq = 8'h00;
        wait_int("t7_int");
        ack();
        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
